// File: rtl/rf_cfg_cmd_parser.sv
// UART configuration-command parser for the RF module while M0=M1=1 (config mode).
// Defining RF_CFG_PARSER_PERSIST_EN adds a saved parameter bank written by C0 and reloaded by C4.
module rf_cfg_cmd_parser #(
   parameter int                                DATA_WIDTH     = 8,
   parameter int                                PARAM_BYTES    = 5,
   parameter logic [PARAM_BYTES*DATA_WIDTH-1:0] DEFAULT_PARAMS = 40'h0000_1A17_44,
   parameter logic [DATA_WIDTH-1:0]             VERSION_ID     = 8'h32,
   parameter int                                TIMEOUT_CYCLES = 50000
) (
   input  logic                                internal_clk,
   input  logic                                rst_n,
   input  logic                                config_mode,
   input  logic [DATA_WIDTH-1:0]               rx_data,
   input  logic                                rx_valid,
   output logic [DATA_WIDTH-1:0]               tx_data,
   output logic                                tx_valid,
   input  logic                                tx_ready,
   output logic                                aux,
   output logic [PARAM_BYTES*DATA_WIDTH-1:0]   params_out,
   output logic                                params_update,
   output logic                                soft_reset_req,
   output logic                                cmd_error
);

   localparam int IMG_W = PARAM_BYTES * DATA_WIDTH;
   localparam int IDX_W = $clog2(PARAM_BYTES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [DATA_WIDTH-1:0] HDR_WR_SAVE = DATA_WIDTH'(8'hC0);
   localparam logic [DATA_WIDTH-1:0] HDR_READ    = DATA_WIDTH'(8'hC1);
   localparam logic [DATA_WIDTH-1:0] HDR_WR_TEMP = DATA_WIDTH'(8'hC2);
   localparam logic [DATA_WIDTH-1:0] HDR_VERSION = DATA_WIDTH'(8'hC3);
   localparam logic [DATA_WIDTH-1:0] HDR_RESET   = DATA_WIDTH'(8'hC4);

   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PARAM_BYTES - 1);
   localparam logic [IDX_W-1:0] IDX_FULL  = IDX_W'(PARAM_BYTES);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_REPEAT  = 2'd2,
      ST_RESPOND = 2'd3
   } state_t;

   state_t                  r_state;
   logic [IDX_W-1:0]        r_idx;
   logic [1:0]              r_rep;
   logic [TMO_W-1:0]        r_tmo;
   logic [DATA_WIDTH-1:0]   r_hdr;
   logic [IMG_W-1:0]        r_shadow;
   logic [IMG_W-1:0]        r_params;
   logic [IMG_W-1:0]        r_rsp;
   logic [IDX_W-1:0]        r_tx_left;
   logic [DATA_WIDTH-1:0]   r_tx_data;
   logic                    r_tx_valid;
   logic                    r_upd;
   logic                    r_srst;
   logic                    r_err;
   logic                    r_aux;

   logic [IMG_W-1:0]        w_shadow_next;
   logic [IMG_W-1:0]        w_reload;

   // Bytes shift in from the right so that the first data byte ends up in the MSB byte.
   assign w_shadow_next = {r_shadow[IMG_W-DATA_WIDTH-1:0], rx_data};

`ifdef RF_CFG_PARSER_PERSIST_EN
   logic [IMG_W-1:0]        r_saved;
   assign w_reload = r_saved;
`else
   assign w_reload = DEFAULT_PARAMS;
`endif

   assign tx_data        = r_tx_data;
   assign tx_valid       = r_tx_valid;
   assign aux            = r_aux;
   assign params_out     = r_params;
   assign params_update  = r_upd;
   assign soft_reset_req = r_srst;
   assign cmd_error      = r_err;

   // Command FSM with all outputs registered.
   always_ff @(posedge internal_clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_rep      <= 2'd0;
         r_tmo      <= '0;
         r_hdr      <= '0;
         r_shadow   <= '0;
         r_params   <= DEFAULT_PARAMS;
`ifdef RF_CFG_PARSER_PERSIST_EN
         r_saved    <= DEFAULT_PARAMS;
`endif
         r_rsp      <= '0;
         r_tx_left  <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_upd      <= 1'b0;
         r_srst     <= 1'b0;
         r_err      <= 1'b0;
         r_aux      <= 1'b0;
      end else begin
         r_upd  <= 1'b0;
         r_srst <= 1'b0;
         r_err  <= 1'b0;
         r_aux  <= (r_state == ST_IDLE);
         case (r_state)
            ST_IDLE: begin
               r_idx <= '0;
               r_rep <= 2'd0;
               r_tmo <= '0;
               if (rx_valid && config_mode) begin
                  if ((rx_data == HDR_WR_SAVE) || (rx_data == HDR_WR_TEMP)) begin
                     r_hdr    <= rx_data;
                     r_shadow <= '0;
                     r_state  <= ST_COLLECT;
                  end else if ((rx_data == HDR_READ) || (rx_data == HDR_VERSION) ||
                               (rx_data == HDR_RESET)) begin
                     r_hdr   <= rx_data;
                     r_rep   <= 2'd1;
                     r_state <= ST_REPEAT;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end

            ST_COLLECT: begin
               if (!config_mode) begin
                  r_state <= ST_IDLE;
               end else if (rx_valid) begin
                  r_tmo    <= '0;
                  r_shadow <= w_shadow_next;
                  if (r_idx == IDX_LAST) begin
                     r_params   <= w_shadow_next;
`ifdef RF_CFG_PARSER_PERSIST_EN
                     if (r_hdr == HDR_WR_SAVE) begin
                        r_saved <= w_shadow_next;
                     end
`endif
                     r_upd      <= 1'b1;
                     r_tx_data  <= r_hdr;
                     r_tx_valid <= 1'b1;
                     r_rsp      <= w_shadow_next;
                     r_tx_left  <= IDX_FULL;
                     r_state    <= ST_RESPOND;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end else if (r_tmo == TMO_LAST) begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end

            ST_REPEAT: begin
               if (!config_mode) begin
                  r_state <= ST_IDLE;
               end else if (rx_valid) begin
                  r_tmo <= '0;
                  if (rx_data != r_hdr) begin
                     r_err   <= 1'b1;
                     r_state <= ST_IDLE;
                  end else if (r_rep == 2'd2) begin
                     r_rep <= 2'd3;
                     case (r_hdr)
                        HDR_READ: begin
                           r_tx_data  <= HDR_WR_SAVE;
                           r_tx_valid <= 1'b1;
                           r_rsp      <= r_params;
                           r_tx_left  <= IDX_FULL;
                           r_state    <= ST_RESPOND;
                        end
                        HDR_VERSION: begin
                           r_tx_data  <= HDR_VERSION;
                           r_tx_valid <= 1'b1;
                           r_rsp      <= {VERSION_ID, {(IMG_W-DATA_WIDTH){1'b0}}};
                           r_tx_left  <= IDX_W'(1);
                           r_state    <= ST_RESPOND;
                        end
                        HDR_RESET: begin
                           r_srst   <= 1'b1;
                           r_params <= w_reload;
                           r_state  <= ST_IDLE;
                        end
                        default: begin
                           r_state <= ST_IDLE;
                        end
                     endcase
                  end else begin
                     r_rep <= r_rep + 2'd1;
                  end
               end else if (r_tmo == TMO_LAST) begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end

            ST_RESPOND: begin
               // Host bytes cannot be queued while a response is draining.
               if (rx_valid) begin
                  r_err <= 1'b1;
               end
               if (r_tx_valid && tx_ready) begin
                  if (r_tx_left == '0) begin
                     r_tx_valid <= 1'b0;
                     r_state    <= ST_IDLE;
                  end else begin
                     r_tx_data <= r_rsp[IMG_W-1 -: DATA_WIDTH];
                     r_rsp     <= {r_rsp[IMG_W-DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
                     r_tx_left <= r_tx_left - IDX_W'(1);
                  end
               end
            end

            default: begin
               r_tx_valid <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rf_cfg_cmd_parser.sv
// Self-checking bench for rf_cfg_cmd_parser: directed scenarios plus randomized command frames
// checked against a frame-level reference model.
module tb_rf_cfg_cmd_parser;

   localparam int          PB  = 5;
   localparam int          IW  = 40;
   localparam int          TMO = 64;
   localparam logic [39:0] DEF = 40'h0000_1A17_44;

   logic        internal_clk = 1'b0;
   logic        rst_n        = 1'b0;
   logic        config_mode  = 1'b0;
   logic [7:0]  rx_data      = 8'h00;
   logic        rx_valid     = 1'b0;
   logic        tx_ready     = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        aux;
   logic [39:0] params_out;
   logic        params_update;
   logic        soft_reset_req;
   logic        cmd_error;

   rf_cfg_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
      .internal_clk  (internal_clk),
      .rst_n         (rst_n),
      .config_mode   (config_mode),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .aux           (aux),
      .params_out    (params_out),
      .params_update (params_update),
      .soft_reset_req(soft_reset_req),
      .cmd_error     (cmd_error)
   );

   always #5 internal_clk = ~internal_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [39:0] m_params = DEF;
   logic [39:0] m_saved  = DEF;
   logic [7:0]  exp_tx[$];
   int          e_upd, e_srst, e_err;

   // Monitor state
   logic [7:0]  got_tx[$];
   int          n_upd = 0, n_srst = 0, n_err = 0, n_stab = 0;
   int          b_upd, b_srst, b_err;
   logic        p_hold = 1'b0;
   logic [7:0]  p_data = 8'h00;
   int          ready_mode = 2;
   int          max_gap = 0;

   initial begin
      forever begin
         @(posedge internal_clk);
         #1;
         case (ready_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b1;
         endcase
      end
   end

   always @(negedge internal_clk) begin
      if (rst_n) begin
         if (tx_valid && tx_ready) got_tx.push_back(tx_data);
         if (params_update) n_upd++;
         if (soft_reset_req) n_srst++;
         if (cmd_error) n_err++;
         if (p_hold && !(tx_valid && (tx_data == p_data))) n_stab++;
         p_hold = tx_valid && !tx_ready;
         p_data = tx_data;
      end else begin
         p_hold = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge internal_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) tick();
   endtask

   function automatic logic [7:0] img_byte(input logic [39:0] img, input int i);
      return img[IW-1-8*i -: 8];
   endfunction

   task automatic push_img(input logic [39:0] img);
      for (int i = 0; i < PB; i++) exp_tx.push_back(img_byte(img, i));
   endtask

   task automatic begin_frame();
      got_tx.delete();
      exp_tx.delete();
      b_upd = n_upd; b_srst = n_srst; b_err = n_err;
      e_upd = 0; e_srst = 0; e_err = 0;
   endtask

   task automatic wait_idle();
      int k = 0;
      int quiet = 0;
      while (quiet < 3 && k < 500) begin
         tick();
         if (aux && !tx_valid) quiet++;
         else quiet = 0;
         k++;
      end
      check_eq("idle_wait", 64'(quiet), 64'd3);
   endtask

   task automatic end_frame(input string tag);
      logic [63:0] g;
      wait_idle();
      check_eq({tag, ".tx_len"}, 64'(got_tx.size()), 64'(exp_tx.size()));
      for (int i = 0; i < exp_tx.size(); i++) begin
         g = (i < got_tx.size()) ? 64'(got_tx[i]) : 64'hFFFF;
         check_eq($sformatf("%s.tx[%0d]", tag, i), g, 64'(exp_tx[i]));
      end
      check_eq({tag, ".params"}, 64'(params_out), 64'(m_params));
      check_eq({tag, ".upd"},  64'(n_upd - b_upd),   64'(e_upd));
      check_eq({tag, ".srst"}, 64'(n_srst - b_srst), 64'(e_srst));
      check_eq({tag, ".err"},  64'(n_err - b_err),   64'(e_err));
   endtask

   task automatic op_write(input logic [7:0] hdr, input logic [39:0] img);
      send_byte(hdr);
      for (int i = 0; i < PB; i++) send_byte(img_byte(img, i));
      exp_tx.push_back(hdr);
      push_img(img);
      m_params = img;
`ifdef RF_CFG_PARSER_PERSIST_EN
      if (hdr == 8'hC0) m_saved = img;
`endif
      e_upd++;
   endtask

   task automatic op_rep(input logic [7:0] hdr);
      repeat (3) send_byte(hdr);
      if (hdr == 8'hC1) begin
         exp_tx.push_back(8'hC0);
         push_img(m_params);
      end else if (hdr == 8'hC3) begin
         exp_tx.push_back(8'hC3);
         exp_tx.push_back(8'h32);
      end else begin
`ifdef RF_CFG_PARSER_PERSIST_EN
         m_params = m_saved;
`else
         m_params = DEF;
`endif
         e_srst++;
      end
   endtask

   task automatic op_mismatch(input logic [7:0] hdr, input int nmatch, input logic [7:0] bad);
      send_byte(hdr);
      repeat (nmatch) send_byte(hdr);
      send_byte(bad);
      e_err++;
   endtask

   task automatic op_timeout(input logic [7:0] hdr, input int k, input logic [39:0] img);
      send_byte(hdr);
      for (int i = 0; i < k; i++) send_byte(img_byte(img, i));
      repeat (TMO + 8) tick();
      e_err++;
   endtask

   task automatic op_abort(input logic [7:0] hdr, input int k, input logic [39:0] img);
      send_byte(hdr);
      for (int i = 0; i < k; i++) send_byte(img_byte(img, i));
      config_mode = 1'b0;
      tick();
      config_mode = 1'b1;
   endtask

   task automatic op_ignored(input int n);
      config_mode = 1'b0;
      for (int i = 0; i < n; i++) send_byte(8'($urandom_range(8'hC0, 8'hC4)));
      config_mode = 1'b1;
   endtask

   task automatic op_busy_rx();
      ready_mode = 0;
      op_rep(8'hC3);
      tick();
      send_byte(8'h5A);
      e_err++;
      ready_mode = 1;
   endtask

   logic [39:0] rimg;
   logic [7:0]  rb, rh;
   int          kind;

   initial begin
      // Reset values while rst_n is held low
      repeat (3) tick();
      check_eq("rst.tx_valid", 64'(tx_valid), 64'd0);
      check_eq("rst.tx_data",  64'(tx_data),  64'd0);
      check_eq("rst.params",   64'(params_out), 64'(DEF));
      check_eq("rst.upd",      64'(params_update), 64'd0);
      check_eq("rst.srst",     64'(soft_reset_req), 64'd0);
      check_eq("rst.err",      64'(cmd_error), 64'd0);
      check_eq("rst.aux",      64'(aux), 64'd0);
      rst_n = 1'b1;
      config_mode = 1'b1;
      tick(); tick();
      check_eq("post_rst.aux", 64'(aux), 64'd1);

      // Write C0 27 02 FF 00 AA
      begin_frame();
      op_write(8'hC0, 40'h2702FF00AA);
      end_frame("req017");

      // Read back with tx_ready held low first
      begin_frame();
      ready_mode = 0;
      op_rep(8'hC1);
      for (int i = 0; i < 10; i++) begin
         check_eq("hold.valid", 64'(tx_valid), 64'd1);
         check_eq("hold.data",  64'(tx_data),  64'hC0);
         check_eq("hold.aux",   64'(aux),      64'd0);
         tick();
      end
      ready_mode = 2;
      end_frame("req018");

      begin_frame();
      op_mismatch(8'hC1, 1, 8'hC3);
      end_frame("req019");

      begin_frame();
      op_timeout(8'hC0, 1, 40'h2711223344);
      end_frame("req020.tmo");
      begin_frame();
      op_rep(8'hC3);
      end_frame("req020.ver");

      begin_frame();
      op_write(8'hC2, 40'h1122334455);
      end_frame("req021.c2");
      begin_frame();
      op_rep(8'hC4);
      end_frame("req021.c4");

      begin_frame();
      op_ignored(3);
      end_frame("req022.cfg0");

      begin_frame();
      op_busy_rx();
      end_frame("busy_rx");

      // Reset in the middle of a C0 frame after moving params away from the defaults
      begin_frame();
      op_write(8'hC2, 40'h5566778899);
      end_frame("pre_rst");
      send_byte(8'hC0);
      send_byte(8'h27);
      send_byte(8'h02);
      rst_n = 1'b0;
      tick(); tick();
      check_eq("midrst.params", 64'(params_out), 64'(DEF));
      check_eq("midrst.aux",    64'(aux), 64'd0);
      check_eq("midrst.tx",     64'(tx_valid), 64'd0);
      rst_n = 1'b1;
      m_params = DEF;
      m_saved  = DEF;
      begin_frame();
      op_rep(8'hC1);
      end_frame("post_midrst");

      // Randomized frames
      max_gap = 3;
      ready_mode = 1;
      for (int f = 0; f < 60; f++) begin
         kind = $urandom_range(0, 10);
         rimg = {$urandom(), 8'($urandom())};
         begin_frame();
         case (kind)
            0: op_write(8'hC0, rimg);
            1: op_write(8'hC2, rimg);
            2: op_rep(8'hC1);
            3: op_rep(8'hC3);
            4: op_rep(8'hC4);
            5: begin
               do rb = 8'($urandom()); while (rb >= 8'hC0 && rb <= 8'hC4);
               send_byte(rb);
               e_err++;
            end
            6: begin
               case ($urandom_range(0, 2))
                  0:       rh = 8'hC1;
                  1:       rh = 8'hC3;
                  default: rh = 8'hC4;
               endcase
               do rb = 8'($urandom()); while (rb == rh);
               op_mismatch(rh, $urandom_range(0, 1), rb);
            end
            7: op_timeout(($urandom_range(0, 1) != 0) ? 8'hC0 : 8'hC2, $urandom_range(0, PB - 1), rimg);
            8: op_ignored($urandom_range(1, 3));
            9: op_abort(($urandom_range(0, 1) != 0) ? 8'hC0 : 8'hC2, $urandom_range(0, PB - 1), rimg);
            default: op_busy_rx();
         endcase
         end_frame($sformatf("rnd%0d.k%0d", f, kind));
      end

      check_eq("tx_stable", 64'(n_stab), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rf_cfg_cmd_parser.md
RF_CFG_CMD_PARSER -- requirements
Module: rf_cfg_cmd_parser

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8, UART byte width.
- PARAM_BYTES, default 5, parameter-frame length after the header.
- DEFAULT_PARAMS, default 40'h0000_1A17_44, reset parameter image, PARAM_BYTES*DATA_WIDTH bits.
- VERSION_ID, default 8'h32, version byte.
- TIMEOUT_CYCLES, default 50000, inter-byte timeout.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- internal_clk  in  1  sole clock.
- rst_n  in  1  synchronous active-low reset.
- config_mode  in  1  high when M0=M1=1.
- rx_data  in  DATA_WIDTH  byte from the MCU UART.
- rx_valid  in  1  one-cycle byte strobe.
- tx_data  out  DATA_WIDTH  response byte.
- tx_valid  out  1  response byte valid.
- tx_ready  in  1  UART TX accepts byte.
- aux  out  1  high = idle, low = busy.
- params_out  out  PARAM_BYTES*DATA_WIDTH  active parameters.
- params_update  out  1  one-cycle commit pulse.
- soft_reset_req  out  1  one-cycle pulse on C4 command.
- cmd_error  out  1  one-cycle error pulse.
REQ-003 The block SHALL use one clock, internal_clk; reset SHALL be synchronous and active-low on rst_n.

Function
REQ-004 States SHALL be IDLE, COLLECT, REPEAT, RESPOND; rx_valid SHALL be ignored, with no error, while config_mode=0 in IDLE.
REQ-005 IDLE behaviour on rx_valid with config_mode=1:
- 8'hC0 or 8'hC2: go to COLLECT with idx=0.
- 8'hC1, 8'hC3 or 8'hC4: go to REPEAT with rep=1.
- Any other byte: pulse cmd_error and stay in IDLE.
REQ-006 COLLECT SHALL store each rx_valid byte into shadow[idx]. Byte 0 SHALL land in the MSB byte of the image. idx width SHALL be clog2(PARAM_BYTES+1).
REQ-007 In COLLECT, on byte PARAM_BYTES-1, the next cycle SHALL:
- copy the shadow to params_out;
- pulse params_update;
- enter RESPOND with an echo of the header plus PARAM_BYTES bytes.
REQ-008 REPEAT SHALL require each following byte to equal the header. A mismatch SHALL pulse cmd_error and return to IDLE. At rep=3 the block SHALL act on the header:
- C1: respond C0 followed by params_out, MSB byte first.
- C3: respond C3, VERSION_ID.
- C4: pulse soft_reset_req, reload parameters per REQ-016, go to IDLE with no response.
REQ-009 In RESPOND, tx_valid SHALL stay high with tx_data stable until tx_valid&tx_ready. The next byte SHALL be presented in the cycle after acceptance. After the last accepted byte the block SHALL return to IDLE.
REQ-010 In RESPOND, rx_valid SHALL be dropped and SHALL pulse cmd_error; RESPOND SHALL complete even if config_mode falls.
REQ-011 In COLLECT or REPEAT:
- A timeout counter SHALL clear on every rx_valid.
- At TIMEOUT_CYCLES-1 the block SHALL pulse cmd_error, discard the shadow, go to IDLE, and leave params_out unchanged.
REQ-012 config_mode falling in COLLECT or REPEAT SHALL abort to IDLE with no error and no commit.
REQ-013 aux SHALL be registered: high one cycle after entering IDLE, low the cycle after leaving IDLE.
REQ-014 rx_valid and tx_ready in the same cycle SHALL both be handled per the current state; there SHALL be no extra latency.

Reset
REQ-015 While rst_n=0, on each internal_clk edge:
- state SHALL be IDLE, idx=0, rep=0, timeout counter=0;
- params_out SHALL be DEFAULT_PARAMS;
- tx_valid, params_update, soft_reset_req, cmd_error and aux SHALL be 0;
- tx_data SHALL be 0.
Reset mid-frame or mid-response SHALL discard all progress.

Configuration
REQ-016 With macro RF_CFG_PARSER_PERSIST_EN defined:
- A saved bank SHALL exist, reset to DEFAULT_PARAMS.
- C0 SHALL write both the active and saved banks; C2 SHALL write the active bank only.
- C4 SHALL reload the active bank from the saved bank.
Without the macro:
- There SHALL be no saved bank.
- C0 and C2 SHALL behave identically.
- C4 SHALL reload DEFAULT_PARAMS.

Verification
REQ-017 config_mode=1, send C0 27 02 FF 00 AA -> params_out=40'h2702FF00AA, one params_update pulse, tx sequence C0 27 02 FF 00 AA.
REQ-018 After REQ-017, send C1 C1 C1 with tx_ready held low 10 cycles -> tx_data stays C0 until ready, then C0 27 02 FF 00 AA; aux is low throughout.
REQ-019 Send C1 C1 C3 -> cmd_error pulse, no tx_valid, state IDLE.
REQ-020 Send C0 27 then no bytes for TIMEOUT_CYCLES -> cmd_error pulse, params_out unchanged; a following C3 C3 C3 -> tx sequence C3 32.
REQ-021 Send C2 11 22 33 44 55 then C4 C4 C4 -> soft_reset_req pulse. params_out becomes 2702FF00AA with the macro (saved bank from REQ-017) and 0000_1A17_44 without it.
REQ-022 With config_mode=0, send C1 C1 C1 -> no response and no error; assert rst_n=0 mid-C0 frame -> params_out=DEFAULT_PARAMS and aux=0.
